// File: rtl/fft_pkg.sv
// Shared constants and sample type for the pipelined FFT sections.
package fft_pkg;
  localparam int DATA_W = 24;
  localparam int FRAC   = 8;
  localparam int HALF_N = 64;

  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_BF   = 2'd1;
  localparam logic [1:0] ST_TW   = 2'd2;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;
endpackage

// File: rtl/cmult_q.sv
// Combinational fixed-point complex multiply: (a_r + j a_i)(b_r + j b_i) >>> FRAC.
// Define SDF_ROUND_EN to round half-up before the shift instead of flooring.
module cmult_q #(
  parameter int DATA_W = 24,
  parameter int FRAC   = 8
) (
  input  logic signed [DATA_W-1:0] a_r,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_r,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [DATA_W-1:0] p_r,
  output logic signed [DATA_W-1:0] p_i
);
  localparam int PW = 2*DATA_W + 1;

`ifdef SDF_ROUND_EN
  localparam logic signed [PW-1:0] RND = PW'(1) <<< (FRAC-1);
`else
  localparam logic signed [PW-1:0] RND = '0;
`endif

  logic signed [PW-1:0] ar, ai, br, bi, re_f, im_f;

  assign ar = {{(PW-DATA_W){a_r[DATA_W-1]}}, a_r};
  assign ai = {{(PW-DATA_W){a_i[DATA_W-1]}}, a_i};
  assign br = {{(PW-DATA_W){b_r[DATA_W-1]}}, b_r};
  assign bi = {{(PW-DATA_W){b_i[DATA_W-1]}}, b_i};

  // Full precision products; the extra bit holds the sum of two max products.
  assign re_f = ar*br - ai*bi + RND;
  assign im_f = ar*bi + ai*br + RND;

  assign p_r = DATA_W'(re_f >>> FRAC);
  assign p_i = DATA_W'(im_f >>> FRAC);
endmodule

// File: rtl/sdf_bf_stage.sv
// Radix-2 SDF butterfly stage: delay-feedback FIFO, add/sub butterfly, twiddle multiply.
// Optional SDF_ROUND_EN selects round half-up in the twiddle multiply.
module sdf_bf_stage #(
  parameter int DATA_W = fft_pkg::DATA_W,
  parameter int DELAY  = fft_pkg::HALF_N,
  parameter int FRAC   = fft_pkg::FRAC
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] din_r,
  input  logic signed [DATA_W-1:0] din_i,
  input  logic [1:0]               state,
  input  logic signed [DATA_W-1:0] w_r,
  input  logic signed [DATA_W-1:0] w_i,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] dout_r,
  output logic signed [DATA_W-1:0] dout_i
);
  import fft_pkg::*;

  localparam int PTR_W = (DELAY > 1) ? $clog2(DELAY) : 1;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } smp_t;

  smp_t             mem [DELAY];
  logic [PTR_W-1:0] ptr;
  smp_t             f, push_v, sum, diff, tw;
  logic             adv, is_bf, is_tw;

  assign f     = mem[ptr];
  assign is_bf = (state == ST_BF);
  assign is_tw = (state == ST_TW);
  // Illegal state 3 never advances, even with in_valid high.
  assign adv   = (state inside {ST_FILL, ST_BF, ST_TW}) && (in_valid || is_bf || is_tw);

  assign sum.re  = f.re + din_r;
  assign sum.im  = f.im + din_i;
  assign diff.re = f.re - din_r;
  assign diff.im = f.im - din_i;

  cmult_q #(.DATA_W(DATA_W), .FRAC(FRAC)) u_cmult (
    .a_r (f.re),
    .a_i (f.im),
    .b_r (w_r),
    .b_i (w_i),
    .p_r (tw.re),
    .p_i (tw.im)
  );

  always_comb begin
    push_v = {din_r, din_i};
    if (is_bf) push_v = diff;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DELAY; i++) mem[i] <= '0;
      ptr       <= '0;
      out_valid <= 1'b0;
      dout_r    <= '0;
      dout_i    <= '0;
    end else begin
      out_valid <= adv && (is_bf || is_tw);
      if (adv) begin
        mem[ptr] <= push_v;
        ptr      <= (ptr == PTR_W'(DELAY-1)) ? '0 : ptr + PTR_W'(1);
        if (is_bf) begin
          dout_r <= sum.re;
          dout_i <= sum.im;
        end else if (is_tw) begin
          dout_r <= tw.re;
          dout_i <= tw.im;
        end
      end
    end
  end
endmodule

// File: tb/tb_sdf_bf_stage.sv
// Scoreboard bench for sdf_bf_stage: queue-based FIFO reference model, monitor on out_valid.
module tb_sdf_bf_stage;
  import fft_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     in_valid = 1'b0;
  logic signed [DATA_W-1:0] din_r = '0, din_i = '0, w_r = '0, w_i = '0;
  logic [1:0]               state = 2'd0;
  logic                     out_valid;
  logic signed [DATA_W-1:0] dout_r, dout_i;

  sdf_bf_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .din_r(din_r), .din_i(din_i),
    .state(state), .w_r(w_r), .w_i(w_i),
    .out_valid(out_valid), .dout_r(dout_r), .dout_i(dout_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int stamp; cplx_t v; } exp_t;
  exp_t  expq[$];
  cplx_t mq[$];
  int    npass = 0, ntot = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    ntot++;
    if (act == req) npass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
  endtask

  // Output checker: every valid beat must match the oldest expectation, one cycle after issue.
  always @(negedge clk) begin
    if (out_valid) begin
      if (expq.size() == 0) chk("spurious_out_valid", 1, 0);
      else begin
        exp_t e;
        e = expq.pop_front();
        chk("dout_r", dout_r, e.v.re);
        chk("dout_i", dout_i, e.v.im);
        chk("latency", cyc, e.stamp + 1);
      end
    end
  end

  function automatic int rnd24();
    logic signed [23:0] t;
    t = 24'($urandom);
    return int'(t);
  endfunction

  function automatic int rndw();
    return int'($urandom_range(0, 512)) - 256;
  endfunction

  function automatic logic signed [DATA_W-1:0] wrap(input longint v);
    return v[DATA_W-1:0];
  endfunction

  // Reference complex multiply: exact product, optional half-up bias, floor shift, wrap.
  function automatic cplx_t cmul(input cplx_t a, input int wr, input int wi);
    longint re, im;
    cplx_t  r;
    re = longint'(a.re) * wr - longint'(a.im) * wi;
    im = longint'(a.re) * wi + longint'(a.im) * wr;
`ifdef SDF_ROUND_EN
    re += longint'(1) << (FRAC-1);
    im += longint'(1) << (FRAC-1);
`endif
    r.re = wrap(re >>> FRAC);
    r.im = wrap(im >>> FRAC);
    return r;
  endfunction

  task automatic model_clear();
    mq.delete();
    for (int i = 0; i < HALF_N; i++) mq.push_back('0);
  endtask

  task automatic step(input logic [1:0] st, input bit vin, input int dr, input int di,
                      input int wr, input int wi);
    cplx_t f, d, o;
    exp_t  e;
    state = st; in_valid = vin;
    din_r = 24'(dr); din_i = 24'(di); w_r = 24'(wr); w_i = 24'(wi);
    d.re = 24'(dr); d.im = 24'(di);
    if (st != 2'd3 && (vin || st == ST_BF || st == ST_TW)) begin
      f = mq.pop_front();
      case (st)
        ST_BF: begin
          mq.push_back('{re: wrap(longint'(f.re) - d.re), im: wrap(longint'(f.im) - d.im)});
          o.re = wrap(longint'(f.re) + d.re);
          o.im = wrap(longint'(f.im) + d.im);
        end
        ST_TW: begin
          mq.push_back(d);
          o = cmul(f, wr, wi);
        end
        default: mq.push_back(d);
      endcase
      if (st != ST_FILL) begin
        e.stamp = cyc; e.v = o;
        expq.push_back(e);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic rand_frame_half(input logic [1:0] st);
    for (int k = 0; k < HALF_N; k++) step(st, 1'b1, rnd24(), rnd24(), rndw(), rndw());
  endtask

  int tw_r[4] = '{181, 0, 128, 128};
  int tw_i[4] = '{-181, -256, 0, 0};
  int tw_d[4] = '{256, 256, 3, -3};

  initial begin
    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      state = 2'($urandom); in_valid = 1'($urandom);
      din_r = 24'($urandom); din_i = 24'($urandom); w_r = 24'($urandom); w_i = 24'($urandom);
      @(posedge clk); #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_dout_r", dout_r, 0);
      chk("rst_dout_i", dout_i, 0);
    end
    rst_n = 1'b1;
    model_clear();

    // Frame A fill with stalls and an illegal-state hold, then BF with constant 100.
    for (int k = 0; k < HALF_N; k++) begin
      if (k == 10 || k == 20) step(ST_FILL, 1'b0, rnd24(), rnd24(), rndw(), rndw());
      if (k == 30) step(2'd3, 1'b1, rnd24(), rnd24(), rndw(), rndw());
      step(ST_FILL, 1'b1, k, 0, rndw(), rndw());
    end
    for (int k = 0; k < HALF_N; k++) step(ST_BF, 1'b1, 100, 0, rndw(), rndw());

    // TW: identity on entry 0, plus directed next-half samples for rotation/rounding.
    for (int k = 0; k < HALF_N; k++)
      step(ST_TW, 1'b1, (k < 4) ? tw_d[k] : int'($urandom_range(0, 2000)) - 1000,
           (k < 4) ? 0 : int'($urandom_range(0, 2000)) - 1000,
           (k == 0) ? 256 : rndw(), (k == 0) ? 0 : rndw());
    for (int k = 0; k < HALF_N; k++) step(ST_BF, 1'b1, 0, 0, rndw(), rndw());
    for (int k = 0; k < HALF_N; k++)
      step(ST_TW, 1'b1, rnd24(), rnd24(), (k < 4) ? tw_r[k] : rndw(), (k < 4) ? tw_i[k] : rndw());

    // Random full-range frames (wraparound exercised).
    rand_frame_half(ST_BF);
    rand_frame_half(ST_TW);

    // Reset in the middle of BF.
    for (int k = 0; k < 10; k++) step(ST_BF, 1'b1, rnd24(), rnd24(), rndw(), rndw());
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_dout_r", dout_r, 0);
    chk("midrst_dout_i", dout_i, 0);
    expq.delete();
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fresh frame after reset.
    for (int k = 0; k < HALF_N; k++) begin
      if (($urandom % 8) == 0) step(ST_FILL, 1'b0, rnd24(), rnd24(), rndw(), rndw());
      step(ST_FILL, 1'b1, rnd24(), rnd24(), rndw(), rndw());
    end
    rand_frame_half(ST_BF);
    rand_frame_half(ST_TW);
    rand_frame_half(ST_BF);
    repeat (3) step(ST_FILL, 1'b0, 0, 0, 0, 0);

    chk("pending_outputs", expq.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
